// File: rtl/sram_port_arb_if.sv
// Requester-side bus of the SRAM port arbiter: packed request lanes plus
// the shared read-response bus.
interface sram_port_arb_if #(
  parameter int NREQ = 4,
  parameter int AW   = 14,
  parameter int DW   = 64
) ();
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;

  // requester side
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  // arbiter side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sram_port_arb.sv
// Shares one dual-port SRAM among NREQ requesters. Writes go to port A and
// reads to port B, each behind its own round-robin arbiter, so one write and
// one read can issue per cycle. Read data returns two cycles after the grant.
// A clear FSM can zero-fill the whole array through port A.
//
// Clear FSM states:
//   state    | meaning
//   ST_IDLE  | no sweep; write arbitration enabled
//   ST_CLEAR | writing zero to address cnt each cycle; write grants blocked
//   ST_DONE  | one-cycle completion pulse; write grants still blocked
module sram_port_arb #(
  parameter int NREQ  = 4,
  parameter int AW    = 14,
  parameter int DW    = 64,
  parameter int DEPTH = 16384
) (
  input  logic          clk,
  input  logic          rstn,
  sram_port_arb_if.slave bus,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          ena,
  output logic          wea,
  output logic [AW-1:0] addra,
  output logic [DW-1:0] dina,
  output logic          enb,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] doutb
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_t;

  clr_state_t    state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  logic [NREQ-1:0] wr_cand, rd_cand, wr_gnt, rd_gnt;
  logic            wr_hit, rd_hit;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic [DW-1:0]   wr_data;
  logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [NREQ-1:0] rd_own;

  // First candidate at or after ptr, wrapping. Scanning from the far end
  // lets the nearest candidate overwrite any later one.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] cand,
                                              input logic [PW-1:0]   ptr);
    logic [NREQ-1:0] gnt;
    int              idx;
    gnt = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (cand[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
    return gnt;
  endfunction

  // Both arbiters, the granted command mux and the pointer advance.
  always_comb begin
    wr_cand    = bus.req_valid & bus.req_we & {NREQ{state == ST_IDLE}};
    rd_cand    = bus.req_valid & ~bus.req_we;
    wr_gnt     = rr_pick(wr_cand, wr_ptr);
    rd_gnt     = rr_pick(rd_cand, rd_ptr);
    wr_hit     = |wr_gnt;
    rd_hit     = |rd_gnt;
    wr_addr    = '0;
    wr_data    = '0;
    rd_addr    = '0;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (wr_gnt[i]) begin
        wr_addr    = bus.req_addr[i*AW +: AW];
        wr_data    = bus.req_wdata[i*DW +: DW];
        wr_ptr_nxt = PW'((i + 1) % NREQ);
      end
      if (rd_gnt[i]) begin
        rd_addr    = bus.req_addr[i*AW +: AW];
        rd_ptr_nxt = PW'((i + 1) % NREQ);
      end
    end
  end

  assign bus.req_ready = wr_gnt | rd_gnt;
  // The SRAM already registers doutb, so the response is a straight pass.
  assign bus.rsp_data  = doutb;

  // Clear FSM next-state and sweep counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (clr_start) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt == AW'(DEPTH - 1)) state_nxt = ST_DONE;
        else                       cnt_nxt   = cnt + 1'b1;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Clear FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Round-robin pointers; each holds when its arbiter grants nothing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Port A: sweep writes take the port while clearing; write grants are
  // blocked then, so the two never collide. Address/data hold when idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ena   <= 1'b0;
      wea   <= 1'b0;
      addra <= '0;
      dina  <= '0;
    end else if (state == ST_CLEAR) begin
      ena   <= 1'b1;
      wea   <= 1'b1;
      addra <= cnt;
      dina  <= '0;
    end else if (wr_hit) begin
      ena   <= 1'b1;
      wea   <= 1'b1;
      addra <= wr_addr;
      dina  <= wr_data;
    end else begin
      ena   <= 1'b0;
      wea   <= 1'b0;
    end
  end

  // Port B issue and the two-stage owner pipeline that tags the response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      enb           <= 1'b0;
      addrb         <= '0;
      rd_own        <= '0;
      bus.rsp_valid <= '0;
    end else begin
      enb <= rd_hit;
      if (rd_hit) addrb <= rd_addr;
      rd_own        <= rd_gnt;
      bus.rsp_valid <= rd_own;
    end
  end

  // Sweep status flags, aligned with the state they describe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_busy <= (state_nxt == ST_CLEAR);
      clr_done <= (state_nxt == ST_DONE);
    end
  end

endmodule
